// File: rtl/pal_cfg_pkg.sv
// Shared types and helpers for the PAL configuration loader.
package pal_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_APPLY_LO,
    ST_APPLY_HI,
    ST_DONE
  } state_e;

  // CRC-8 generator x^8 + x^2 + x + 1 (implicit x^8 term)
  localparam logic [7:0] CRC_POLY = 8'h07;

  // Chain length: two input-plane columns per stage plus the output plane
  function automatic int unsigned cfg_bits(input int unsigned n, input int unsigned m,
                                           input int unsigned p);
    return 2 * n * p + p * m;
  endfunction

  // One serial CRC-8 step, data taken MSB-first
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/pal_cfg_clkgen.sv
// Half-period timer: while run_i is high, tick_o pulses on the last cycle of
// every HALF_PER-cycle phase. Dropping run_i restarts the phase.
module pal_cfg_clkgen #(
  parameter int unsigned HALF_PER = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(HALF_PER + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == CW'(HALF_PER - 1));

  // Count up within a phase; restart after a tick or while idle
  always_comb begin
    cnt_d = '0;
    if (run_i && !tick_o) cnt_d = cnt_q + CW'(1);
  end

  // Phase counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pal_cfg_loader.sv
// PAL serial configuration streamer: takes CFG_BITS bits as bytes over
// valid/ready, shifts them MSB-first on cfg_clk, then pulses cfg_clk once
// with cfg_en high to apply the chain.
// Optional: define PAL_CFG_LOADER_CRC_EN to add a crc[7:0] output (CRC-8 over
// the shifted bits, stable from the done pulse until the next start).
module pal_cfg_loader
  import pal_cfg_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned M        = 5,
  parameter int unsigned P        = 11,
  parameter int unsigned CFG_BITS = cfg_bits(N, M, P),
  parameter int unsigned HALF_PER = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       cfg_bit,
  output logic       cfg_clk,
  output logic       cfg_en,
  output logic       busy,
  output logic       done
`ifdef PAL_CFG_LOADER_CRC_EN
  ,
  output logic [7:0] crc
`endif
);

  localparam int unsigned BW = $clog2(CFG_BITS + 1);

  state_e        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [BW-1:0] sent_q, sent_d;
  logic [3:0]    nib_q, nib_d;
  logic [BW-1:0] remain;
  logic          run, tick, hs;

  logic in_ready_q, in_ready_d;
  logic cfg_bit_q, cfg_bit_d;
  logic cfg_clk_q, cfg_clk_d;
  logic cfg_en_q, cfg_en_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  assign run = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI) ||
               (state_q == ST_APPLY_LO) || (state_q == ST_APPLY_HI);
  assign hs  = in_valid && in_ready_q;

  pal_cfg_clkgen #(.HALF_PER(HALF_PER)) u_clkgen (
    .clk    (clk),
    .rst_n  (rst_n),
    .run_i  (run),
    .tick_o (tick)
  );

  // Next-state logic for the FSM and the bit/byte counters
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    sent_d  = sent_q;
    nib_d   = nib_q;
    remain  = BW'(CFG_BITS) - sent_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_FETCH;
        sent_d  = '0;
      end
      ST_FETCH: if (hs) begin
        shreg_d = in_data;
        nib_d   = (remain >= BW'(8)) ? 4'd8 : remain[3:0];
        state_d = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: if (tick) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: if (tick) begin
        shreg_d = {shreg_q[6:0], 1'b0};
        sent_d  = sent_q + BW'(1);
        nib_d   = nib_q - 4'd1;
        if (sent_d == BW'(CFG_BITS)) state_d = ST_APPLY_LO;
        else if (nib_d == 4'd0)      state_d = ST_FETCH;
        else                         state_d = ST_SHIFT_LO;
      end
      ST_APPLY_LO: if (tick) state_d = ST_APPLY_HI;
      ST_APPLY_HI: if (tick) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Registered outputs are decoded from the next state so they line up with it;
  // cfg_bit changes only when entering SHIFT_LO and is held through SHIFT_HI/FETCH
  always_comb begin
    in_ready_d = (state_d == ST_FETCH);
    cfg_clk_d  = (state_d == ST_SHIFT_HI) || (state_d == ST_APPLY_HI);
    cfg_en_d   = (state_d == ST_APPLY_LO) || (state_d == ST_APPLY_HI);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    cfg_bit_d  = 1'b0;
    if (state_d == ST_SHIFT_LO) cfg_bit_d = shreg_d[7];
    else if ((state_d == ST_SHIFT_HI) || (state_d == ST_FETCH)) cfg_bit_d = cfg_bit_q;
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      sent_q     <= '0;
      nib_q      <= '0;
      in_ready_q <= 1'b0;
      cfg_bit_q  <= 1'b0;
      cfg_clk_q  <= 1'b0;
      cfg_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      sent_q     <= sent_d;
      nib_q      <= nib_d;
      in_ready_q <= in_ready_d;
      cfg_bit_q  <= cfg_bit_d;
      cfg_clk_q  <= cfg_clk_d;
      cfg_en_q   <= cfg_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign cfg_bit  = cfg_bit_q;
  assign cfg_clk  = cfg_clk_q;
  assign cfg_en   = cfg_en_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef PAL_CFG_LOADER_CRC_EN
  logic [7:0] crc_q, crc_d;

  // CRC cleared on start, advanced with each bit as it leaves SHIFT_HI
  always_comb begin
    crc_d = crc_q;
    if ((state_q == ST_IDLE) && start)      crc_d = '0;
    else if ((state_q == ST_SHIFT_HI) && tick) crc_d = crc8_step(crc_q, shreg_q[7]);
  end

  // CRC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;
`endif

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Self-checking bench for pal_cfg_loader: table of load scenarios, random
// loads with source gaps, and hand-written reset / start+abort sequences.
module tb_pal_cfg_loader;

  localparam int unsigned N    = 8;
  localparam int unsigned M    = 5;
  localparam int unsigned P    = 11;
  localparam int unsigned HP   = 2;
  localparam int unsigned CFG  = 2 * N * P + P * M;          // 231
  localparam int unsigned NB   = (CFG + 7) / 8;              // 29
  localparam int FULL_CYC = CFG * 2 * HP + NB + 2 * HP + 1;  // 958 busy cycles

  logic clk = 1'b0;
  logic rst_n, start, abort, in_valid, in_ready;
  logic [7:0] in_data;
  logic cfg_bit, cfg_clk, cfg_en, busy, done;
`ifdef PAL_CFG_LOADER_CRC_EN
  logic [7:0] crc;
`endif

  always #5 clk = ~clk;

  pal_cfg_loader #(.N(N), .M(M), .P(P), .HALF_PER(HP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .cfg_bit  (cfg_bit),
    .cfg_clk  (cfg_clk),
    .cfg_en   (cfg_en),
    .busy     (busy),
    .done     (done)
`ifdef PAL_CFG_LOADER_CRC_EN
    ,
    .crc      (crc)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Bitstream the PAL should receive: bytes MSB-first, truncated to CFG bits
  logic [7:0] bytes_a [NB];
  function automatic logic model_bit(input int i);
    logic [7:0] b;
    b = bytes_a[i / 8];
    return b[7 - (i % 8)];
  endfunction

`ifdef PAL_CFG_LOADER_CRC_EN
  // CRC as the remainder of (message * x^8) mod G by long division
  function automatic logic [7:0] crc_ref(input int nbits);
    bit r [CFG + 8];
    logic [8:0] gen;
    logic [7:0] res;
    gen = 9'h107;
    for (int i = 0; i < CFG + 8; i++) r[i] = (i < nbits) ? model_bit(i) : 1'b0;
    for (int i = 0; i < nbits; i++)
      if (r[i]) for (int j = 0; j < 9; j++) r[i + j] ^= gen[8 - j];
    for (int j = 0; j < 8; j++) res[7 - j] = r[nbits + j];
    return res;
  endfunction
`endif

  typedef struct {
    logic [7:0] first;
    logic [7:0] fill;
    bit         rnd;
    bit         stall;
    int         abort_edge;
    bit         restart;
    int         exp_shift;
    int         exp_apply;
    int         exp_done;
    int         exp_busy;
  } vec_t;

  int n_shift, n_apply, n_done, n_busy, n_stall_viol, n_order;
  bit shift_bits [$];

  // One load: drive start, feed bytes, observe edges; all sampling on negedge
  task automatic run_load(input bit stall, input int abort_edge, input bit restart,
                          input bit gaps, output bit timed_out);
    int idx = 0, cyc = 0, tail = 0, stall_left = 0;
    bit pend = 0, prev_clk = 0, stalled = 0, aborted = 0, abort_chk = 0, restarted = 0;
    shift_bits.delete();
    n_shift = 0; n_apply = 0; n_done = 0; n_busy = 0; n_stall_viol = 0; n_order = 0;
    timed_out = 1;
    @(negedge clk);
    start = 1; in_valid = 0;
    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = 0; abort = 0;
      if (cfg_clk && !prev_clk) begin
        if (cfg_en) begin
          n_apply++;
          if (cfg_bit) n_order++;
        end else begin
          if (n_apply > 0) n_order++;
          n_shift++;
          shift_bits.push_back(cfg_bit);
        end
      end
      prev_clk = cfg_clk;
      if (done) n_done++;
      if (busy) n_busy++;
      if (stall_left > 0 && cfg_clk) n_stall_viol++;
      if (abort_chk) begin
        chk("abort_busy", busy, 0);
        chk("abort_cfg_clk", cfg_clk, 0);
        chk("abort_cfg_en", cfg_en, 0);
        chk("abort_cfg_bit", cfg_bit, 0);
        abort_chk = 0;
      end
      if (pend) idx++;
      if (n_done > 0 || aborted) begin
        tail++;
        if (tail == 10) begin
          timed_out = 0;
          break;
        end
      end
      if (abort_edge > 0 && !aborted && (n_shift + n_apply) == abort_edge) begin
        abort = 1; aborted = 1; abort_chk = 1;
      end
      if (restart && !restarted && n_shift == 50) begin
        start = 1; restarted = 1;
      end
      if (stall && !stalled && idx == 3 && in_ready) begin
        stalled = 1; stall_left = 20;
      end
      in_valid = (stall_left == 0) && (idx < NB) && (!gaps || $urandom_range(0, 3) != 0);
      in_data  = (idx < NB) ? bytes_a[idx] : 8'h00;
      if (stall_left > 0) stall_left--;
      pend = in_valid && in_ready;
    end
    in_valid = 0;
  endtask

  task automatic apply_vec(input vec_t v);
    bit to;
    int nbit_err;
    for (int i = 0; i < NB; i++) bytes_a[i] = v.rnd ? 8'($urandom) : v.fill;
    if (!v.rnd) bytes_a[0] = v.first;
    run_load(v.stall, v.abort_edge, v.restart, v.rnd, to);
    chk("load_timeout", to, 0);
    chk("shift_edges", n_shift, v.exp_shift);
    chk("apply_edges", n_apply, v.exp_apply);
    chk("done_pulses", n_done, v.exp_done);
    if (v.exp_busy >= 0) chk("busy_cycles", n_busy, v.exp_busy);
    chk("edge_order_en", n_order, 0);
    chk("stall_cfg_clk", n_stall_viol, 0);
    chk("end_idle", {busy, in_ready, cfg_en}, 0);
    nbit_err = 0;
    for (int i = 0; i < shift_bits.size() && i < CFG; i++)
      if (shift_bits[i] !== model_bit(i)) nbit_err++;
    chk("bit_stream", nbit_err, 0);
`ifdef PAL_CFG_LOADER_CRC_EN
    if (v.exp_done == 1) chk("crc", crc, crc_ref(CFG));
    if (v.exp_done == 1 && !v.rnd && v.first == 8'h00 && v.fill == 8'h00) chk("crc_zero", crc, 0);
`endif
  endtask

  vec_t tbl [7];
  int viol;
  bit seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hA5, 8'hA5, 0, 0, 0,   0, CFG, 1, 1, FULL_CYC};
    tbl[1] = '{8'hA5, 8'hA5, 0, 1, 0,   0, CFG, 1, 1, FULL_CYC + 20};
    // abort on edge 100: bit 99 is in byte 12, so 13 fetches + 99 bits + LO half
    tbl[2] = '{8'hA5, 8'hA5, 0, 0, 100, 0, 100, 0, 0, 13 + 99 * 4 + 2 + 1};
    tbl[3] = '{8'h3C, 8'hC3, 0, 0, 0,   0, CFG, 1, 1, FULL_CYC};
    tbl[4] = '{8'hA5, 8'hA5, 0, 0, 0,   1, CFG, 1, 1, FULL_CYC};
    tbl[5] = '{8'h00, 8'h00, 0, 0, 0,   0, CFG, 1, 1, FULL_CYC};
    tbl[6] = '{8'h80, 8'h00, 0, 0, 0,   0, CFG, 1, 1, FULL_CYC};

    rst_n = 0; start = 0; abort = 0; in_valid = 0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {in_ready, cfg_bit, cfg_clk, cfg_en, busy, done}, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 7; t++) apply_vec(tbl[t]);

    for (int r = 0; r < 3; r++)
      apply_vec('{8'h00, 8'h00, 1, 0, 0, 0, CFG, 1, 1, -1});

    // Asynchronous reset while cfg_clk is high in SHIFT_HI
    for (int i = 0; i < NB; i++) bytes_a[i] = 8'hA5;
    in_data = 8'hA5; in_valid = 1;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (cfg_clk) seen = 1;
    end
    chk("rst_reached_shift_hi", {seen, busy, cfg_bit}, 3'b111);
    #2 rst_n = 0;
    #1;
    chk("rst_async_outputs", {in_ready, cfg_bit, cfg_clk, cfg_en, busy, done}, 0);
    @(negedge clk); rst_n = 1;
    viol = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (in_ready || busy || cfg_clk) viol++;
    end
    chk("rst_release_idle", viol, 0);
    in_valid = 0;

    // start and abort together in IDLE: abort wins
    @(negedge clk); start = 1; abort = 1;
    @(negedge clk); start = 0; abort = 0;
    viol = 0;
    for (int c = 0; c < 6; c++) begin
      if (in_ready || busy || cfg_clk) viol++;
      @(negedge clk);
    end
    chk("start_abort_idle", viol, 0);

    apply_vec(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
